// File: rtl/sysarray_prune_pkg.sv
// Shared types and width derivations for the head-pruning mean stage.
package sysarray_prune_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    RESULT
  } state_t;

  // Divisor 2*N*N is a power of two, so the mean is a pure arithmetic shift.
  function automatic int shift_w(input int n);
    return $clog2(2 * n * n);
  endfunction

  function automatic int acc_w(input int width, input int n);
    return 2 * width + shift_w(n);
  endfunction

  function automatic bit n_is_legal(input int n);
    return (n >= 2) && (n <= 16) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sysarray_head_prune_mean_row_sum_tree.sv
// Combinational balanced adder tree over the 2N signed elements of one row pair.
module row_sum_tree
  import sysarray_prune_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int ACC_W = acc_w(WIDTH, N)
) (
  input  logic [N*2*WIDTH-1:0]    row1,
  input  logic [N*2*WIDTH-1:0]    row2,
  output logic signed [ACC_W-1:0] sum
);

  localparam int EW     = 2 * WIDTH;
  localparam int LEAVES = 2 * N;

  // Heap layout: node 1 is the root, leaves occupy LEAVES..2*LEAVES-1.
  logic signed [ACC_W-1:0] node [1:2*LEAVES-1];

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign node[LEAVES+i]   = ACC_W'($signed(row1[i*EW +: EW]));
    assign node[LEAVES+N+i] = ACC_W'($signed(row2[i*EW +: EW]));
  end

  for (genvar k = 1; k < LEAVES; k++) begin : g_add
    assign node[k] = node[2*k] + node[2*k+1];
  end

  assign sum = node[1];

endmodule

// File: rtl/sysarray_head_prune_mean.sv
// Accumulates an N x N matrix pair row by row, forms its mean and records a
// per-head prune decision against a signed threshold.
module sysarray_head_prune_mean
  import sysarray_prune_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int HEADS = 4
) (
  input  logic                     clk,
  input  logic                     _reset,
  input  logic                     start,
  input  logic [$clog2(HEADS)-1:0] head_id,
  input  logic [2*WIDTH-1:0]       threshold,
  input  logic                     mask_clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*2*WIDTH-1:0]     row1,
  input  logic [N*2*WIDTH-1:0]     row2,
  input  logic                     in_last,
  output logic [2*WIDTH-1:0]       mean_out,
  output logic                     mean_valid,
  output logic                     len_err,
  output logic                     busy,
  output logic [HEADS-1:0]         prune_mask
);

  localparam int EW    = 2 * WIDTH;
  localparam int ACC_W = acc_w(WIDTH, N);
  localparam int SHIFT = shift_w(N);
  localparam int HW    = $clog2(HEADS);
  localparam int CW    = $clog2(N);

  if (!n_is_legal(N) || HEADS < 2) begin : g_bad_param
    $error("sysarray_head_prune_mean: N must be a power of 2 in 2..16 and HEADS >= 2");
  end

  state_t                  state_q, state_d;
  logic                    start_ok, beat, end_beat, on_last_row;
  logic [CW-1:0]           cnt_q;
  logic                    drain_q;
  logic signed [ACC_W-1:0] row_sum, s1_sum_q, acc_q;
  logic                    s1_vld_q;
  logic [HW-1:0]           head_q;
  logic signed [EW-1:0]    thr_q, mean;
  logic                    len_err_q, prune;
  logic [HEADS-1:0]        mask_d;

  row_sum_tree #(.WIDTH(WIDTH), .N(N), .ACC_W(ACC_W)) u_tree (
    .row1 (row1),
    .row2 (row2),
    .sum  (row_sum)
  );

  assign on_last_row = (cnt_q == CW'(N - 1));
  assign beat        = in_valid && in_ready;
  assign end_beat    = beat && (in_last || on_last_row);
  assign mean        = acc_q[ACC_W-1:SHIFT];
  assign prune       = (mean < thr_q);
  assign busy        = (state_q != IDLE) || mean_valid;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    start_ok = 1'b0;
    case (state_q)
      IDLE: begin
        // Holding off during the mean_valid cycle spaces back-to-back pairs.
        if (start && !mean_valid) begin
          start_ok = 1'b1;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || on_last_row)) state_d = DRAIN;
      end
      DRAIN:   if (drain_q) state_d = RESULT;
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mask_d = mask_clear ? '0 : prune_mask;
    if (state_q == RESULT) mask_d[head_q] = prune;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      s1_sum_q   <= '0;
      s1_vld_q   <= 1'b0;
      acc_q      <= '0;
      head_q     <= '0;
      thr_q      <= '0;
      len_err_q  <= 1'b0;
      mean_out   <= '0;
      mean_valid <= 1'b0;
      len_err    <= 1'b0;
      prune_mask <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= (state_q == DRAIN) && !drain_q;
      s1_vld_q <= beat;
      if (beat) s1_sum_q <= row_sum;

      if (start_ok) begin
        acc_q     <= '0;
        cnt_q     <= '0;
        head_q    <= head_id;
        thr_q     <= threshold;
        len_err_q <= 1'b0;
      end else if (s1_vld_q) begin
        acc_q <= acc_q + s1_sum_q;
      end

      // Missing rows never reach the accumulator, which is the same as zeros.
      if (beat) cnt_q <= cnt_q + CW'(1);
      if (end_beat) len_err_q <= !(in_last && on_last_row);

      mean_valid <= (state_q == RESULT);
      len_err    <= (state_q == RESULT) && len_err_q;
      if (state_q == RESULT) mean_out <= mean;
      prune_mask <= mask_d;
    end
  end

endmodule

// File: tb/tb_sysarray_head_prune_mean.sv
// Directed bench with a queue-based mean/mask model checked on every mean_valid.
module tb_sysarray_head_prune_mean;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int HEADS = 4;
  localparam int EW    = 2 * WIDTH;
  localparam int DIV   = 2 * N * N;

  logic               clk = 1'b0;
  logic               rst;
  logic               start, mask_clear, in_valid, in_last;
  logic [1:0]         head_id;
  logic [EW-1:0]      threshold;
  logic [N*EW-1:0]    row1, row2;
  logic               in_ready, mean_valid, len_err, busy;
  logic [EW-1:0]      mean_out;
  logic [HEADS-1:0]   prune_mask;

  sysarray_head_prune_mean #(.WIDTH(WIDTH), .N(N), .HEADS(HEADS)) dut (
    .clk        (clk),
    ._reset     (rst),
    .start      (start),
    .head_id    (head_id),
    .threshold  (threshold),
    .mask_clear (mask_clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .row1       (row1),
    .row2       (row2),
    .in_last    (in_last),
    .mean_out   (mean_out),
    .mean_valid (mean_valid),
    .len_err    (len_err),
    .busy       (busy),
    .prune_mask (prune_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int               mean;
    bit               lerr;
    logic [HEADS-1:0] mask;
    int               cyc;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             cur;
  int               bv[N][2*N];
  logic [HEADS-1:0] model_mask;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fill(input int v);
    for (int b = 0; b < N; b++)
      for (int i = 0; i < 2 * N; i++) bv[b][i] = v;
  endtask

  task automatic drive_beat(input int b, input bit last);
    for (int i = 0; i < N; i++) begin
      row1[i*EW +: EW] = EW'(bv[b][i]);
      row2[i*EW +: EW] = EW'(bv[b][N+i]);
    end
    in_last  = last;
    in_valid = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst && mean_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL spurious mean_valid at cycle %0d", cyc);
      end else begin
        cur = exp_q.pop_front();
        check("mean_out", $signed(mean_out), cur.mean);
        check("len_err", len_err, cur.lerr);
        check("prune_mask", prune_mask, cur.mask);
        check("mean_valid latency", cyc, cur.cyc);
      end
    end else if (!rst) begin
      check("len_err without mean_valid", len_err, 0);
    end
  end

  // Mean is the floor of the total over 2*N*N elements; missing rows add zero.
  task automatic run_pair(input int h, input int thr, input int last_at,
                          input int gap, input bit poke, input bit clr);
    int   rows, sum, m, w, t_last;
    exp_t e;
    rows = (last_at >= 0) ? last_at + 1 : N;
    sum  = 0;
    for (int b = 0; b < rows; b++)
      for (int i = 0; i < 2 * N; i++) sum += bv[b][i];
    m = sum / DIV;
    if ((sum % DIV != 0) && (sum < 0)) m--;
    if (clr) model_mask = '0;
    model_mask[h] = (m < thr);
    e.mean = m;
    e.lerr = (last_at != N - 1);
    e.mask = model_mask;

    @(posedge clk); #1;
    start = 1'b1; head_id = 2'(h); threshold = EW'(thr);
    @(posedge clk); #1;
    start = 1'b0;
    check("in_ready after start", in_ready, 1);

    for (int b = 0; b < rows; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          if (poke && g == 0) begin
            start = 1'b1; head_id = 2'(h + 1); threshold = EW'(-100);
          end
          @(posedge clk); #1;
          if (poke && g == 0) check("busy during ACCUM", busy, 1);
          start = 1'b0; head_id = 2'(h); threshold = EW'(thr);
        end
      end
      drive_beat(b, b == last_at);
      w = 0;
      while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
    end
    t_last   = cyc;
    e.cyc    = t_last + 3;
    exp_q.push_back(e);
    in_valid = 1'b0;
    in_last  = 1'b0;

    if (clr) begin
      repeat (2) @(posedge clk);
      #1 mask_clear = 1'b1;
      @(posedge clk); #1;
      mask_clear = 1'b0;
    end
    w = 0;
    while (busy && w < 30) begin @(posedge clk); #1; w++; end
    check("busy drop cycle", cyc, t_last + 4);
    check("mean_valid delivered", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mask_clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    head_id = '0; threshold = '0; row1 = '0; row2 = '0;
    model_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 0);
    check("reset mean_out", mean_out, 0);
    check("reset mean_valid", mean_valid, 0);
    check("reset len_err", len_err, 0);
    check("reset busy", busy, 0);
    check("reset prune_mask", prune_mask, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    fill(16);
    run_pair(2, 20, 3, 0, 1'b0, 1'b0);
    check("t1 literal mean 16", $signed(mean_out), 16);
    check("t1 literal mask", prune_mask, 4'b0100);

    run_pair(1, 16, 3, 0, 1'b0, 1'b0);
    check("t2 literal mask strict", prune_mask, 4'b0100);

    fill(-3);
    run_pair(3, 0, 3, 0, 1'b0, 1'b0);
    check("t3 literal mean -3", $signed(mean_out), -3);

    fill(0); bv[0][0] = -1;
    run_pair(0, -1, 3, 0, 1'b0, 1'b0);
    check("t4 literal mean -1", $signed(mean_out), -1);

    fill(0); bv[1][5] = 31;
    run_pair(0, 1, 3, 0, 1'b0, 1'b0);
    check("t5 literal mean 0", $signed(mean_out), 0);

    fill(16);
    run_pair(1, 17, 3, 2, 1'b1, 1'b0);
    check("t6 literal mask", prune_mask, 4'b1111);

    fill(32);
    run_pair(2, 0, 1, 0, 1'b0, 1'b0);
    check("t7 literal early-last mean", $signed(mean_out), 16);

    fill(1);
    run_pair(3, 5, -1, 0, 1'b0, 1'b0);

    fill(-32768);
    run_pair(2, -32768, 3, 0, 1'b0, 1'b0);
    fill(32767);
    run_pair(0, 32767, 3, 0, 1'b0, 1'b0);
    check("t10 literal max mean", $signed(mean_out), 32767);

    // Reset in the middle of a pair: two beats in, reset on the third.
    fill(5);
    @(posedge clk); #1;
    start = 1'b1; head_id = 2'd1; threshold = EW'(100);
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      drive_beat(b, 1'b0);
      @(posedge clk); #1;
    end
    drive_beat(2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst in_ready", in_ready, 0);
    check("midrst mean_out", mean_out, 0);
    check("midrst mean_valid", mean_valid, 0);
    check("midrst len_err", len_err, 0);
    check("midrst busy", busy, 0);
    check("midrst prune_mask", prune_mask, 0);
    rst = 1'b0; in_valid = 1'b0;
    model_mask = '0;
    repeat (8) @(posedge clk);
    #1 check("midrst no pending result", exp_q.size(), 0);

    fill(16);
    run_pair(1, 100, 3, 0, 1'b0, 1'b0);
    run_pair(0, 100, 3, 0, 1'b0, 1'b1);
    check("clear+set literal mask", prune_mask, 4'b0001);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
